// File: rtl/mem_stage_controller_pkg.sv
// Shared constants for the MEM-stage controller: default datapath width,
// timeout default, FSM state encoding and MemtoReg write-back selects.
package mem_stage_controller_pkg;

    localparam int DEFAULT_WORD_SIZE      = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 15;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // MemtoReg encodings; 2'd3 falls back to the ALU result
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC1 = 2'd2;

    // A MEM-stage instruction touches data memory when it loads or stores
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_stage_controller_if.sv
// Data-memory request/response bus between the MEM-stage controller
// (master) and the data memory (slave).
interface mem_stage_controller_if
    import mem_stage_controller_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) ();

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ack;
    logic [WORD_SIZE-1:0] d_rdata;

    modport master (
        output d_req,
        output d_we,
        output d_address,
        output d_wdata,
        input  d_ack,
        input  d_rdata
    );

    modport slave (
        input  d_req,
        input  d_we,
        input  d_address,
        input  d_wdata,
        output d_ack,
        output d_rdata
    );

endinterface

// File: rtl/mem_stage_controller_mem_wb_register.sv
// MEM/WB pipeline latch. Selects the write-back source (ALU result, memory
// data register, or PC+1) and inserts a bubble while the MEM stage stalls.
module mem_wb_register
    import mem_stage_controller_pkg::*;
#(
    parameter int W = DEFAULT_WORD_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_i,
    input  logic         reg_we_i,
    input  logic [1:0]   sel_i,
    input  logic [1:0]   reg_addr_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mdr_i,
    input  logic [W-1:0] pc_i,
    output logic         wb_we_o,
    output logic [1:0]   wb_reg_addr_o,
    output logic [W-1:0] wb_data_o
);

    logic         we_q;
    logic [1:0]   addr_q;
    logic [W-1:0] data_q, data_d;

    // Write-back source mux; PC+1 wraps naturally at W bits
    always_comb begin
        data_d = alu_i;
        case (sel_i)
            WB_SEL_MEM: data_d = mdr_i;
            WB_SEL_PC1: data_d = pc_i + W'(1);
            default:    data_d = alu_i;
        endcase
    end

    // Latch on free-running cycles; a stall leaves a bubble and holds data
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (stall_i) begin
            we_q   <= 1'b0;
        end else begin
            we_q   <= reg_we_i;
            addr_q <= reg_addr_i;
            data_q <= data_d;
        end
    end

    assign wb_we_o       = we_q;
    assign wb_reg_addr_o = addr_q;
    assign wb_data_o     = data_q;

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage controller: issues one data-memory access per load/store,
// stalls the upstream pipeline until the memory acknowledges, then hands
// the result to the MEM/WB latch.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that see no
// d_ack within TIMEOUT_CYCLES ACCESS cycles and raise a sticky mem_error.
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int WORD_SIZE      = DEFAULT_WORD_SIZE,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_readM_MEM,
    input  logic                 d_writeM_MEM,
    input  logic [WORD_SIZE-1:0] ALU_out_MEM,
    input  logic [WORD_SIZE-1:0] RF_data2_MEM,
    input  logic [WORD_SIZE-1:0] pc_MEM,
    input  logic                 RegWrite_MEM,
    input  logic [1:0]           MemtoReg_MEM,
    input  logic [1:0]           write_reg_addr_MEM,
    mem_stage_controller_if.master dmem,
    output logic                 mem_stall,
    output logic                 wb_we,
    output logic [1:0]           wb_reg_addr,
    output logic [WORD_SIZE-1:0] wb_data
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                 mem_error
`endif
);

    logic [1:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] mdr_q, mdr_d;
    logic                 mem_op;

    assign mem_op = is_mem_op(d_readM_MEM, d_writeM_MEM);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    // Last permitted ACCESS cycle reached; d_ack in this same cycle still wins
    assign timeout_hit = (state_q == ST_ACCESS) &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // ACCESS-cycle counter restarts every time the FSM leaves ACCESS
    always_comb begin
        cnt_d = (state_q == ST_ACCESS) ? cnt_q + CNT_W'(1) : '0;
        err_d = err_q | (timeout_hit & ~dmem.d_ack);
    end

    // Counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_error = err_q;
`endif

    // FSM next state plus capture of the request and of the returned data
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        mdr_d   = mdr_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d = ST_ACCESS;
                    addr_d  = ALU_out_MEM;
                    wdata_d = RF_data2_MEM;
                    // read+write together resolves to a write
                    we_d    = d_writeM_MEM;
                end
            end
            ST_ACCESS: begin
                if (dmem.d_ack) begin
                    mdr_d   = dmem.d_rdata;
                    state_d = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    mdr_d   = '0;
                    state_d = ST_DONE;
                end
`endif
            end
            // DONE releases the stall for one cycle so the pipeline advances
            // past this instruction before IDLE can look at it again
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and request/MDR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            mdr_q   <= mdr_d;
        end
    end

    // The IDLE term is combinational so upstream freezes on the first cycle
    assign mem_stall = ((state_q == ST_IDLE) && mem_op) || (state_q == ST_ACCESS);

    assign dmem.d_req     = (state_q == ST_ACCESS);
    assign dmem.d_we      = (state_q == ST_ACCESS) && we_q;
    assign dmem.d_address = addr_q;
    assign dmem.d_wdata   = wdata_q;

    mem_wb_register #(
        .W (WORD_SIZE)
    ) u_mem_wb (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (mem_stall),
        .reg_we_i      (RegWrite_MEM),
        .sel_i         (MemtoReg_MEM),
        .reg_addr_i    (write_reg_addr_MEM),
        .alu_i         (ALU_out_MEM),
        .mdr_i         (mdr_q),
        .pc_i          (pc_MEM),
        .wb_we_o       (wb_we),
        .wb_reg_addr_o (wb_reg_addr),
        .wb_data_o     (wb_data)
    );

endmodule
